// File: rtl/anc_seq_pkg.sv
// rtl/anc_seq_pkg.sv - shared state encodings and widths for the ANC calibration sequencer
package anc_seq_pkg;

    localparam int ANC_SEQ_CNT_W = 18;
    localparam int ANC_SAMPLE_W  = 16;

    typedef enum logic [2:0] {
        ANC_IDLE        = 3'd0,
        ANC_SETTLE      = 3'd1,
        ANC_OFFSET_WAIT = 3'd2,
        ANC_RECORD      = 3'd3,
        ANC_RUN         = 3'd4,
        ANC_FAULT       = 3'd5
    } anc_seq_state_t;

    function automatic logic is_busy_state(input logic [2:0] s);
        return (s == ANC_SETTLE) || (s == ANC_OFFSET_WAIT) || (s == ANC_RECORD);
    endfunction

endpackage

// File: rtl/fade_gain_ramp.sv
// rtl/fade_gain_ramp.sv - saturating fade-in gain ramp, present only when ANC_SEQ_FADE_EN is defined
`ifdef ANC_SEQ_FADE_EN
module fade_gain_ramp #(
    parameter int FADE_SHIFT = 10
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                clear_i,
    input  logic                enable_i,
    input  logic                tick_i,
    output logic [FADE_SHIFT:0] gain_o
);

    localparam logic [FADE_SHIFT:0] GAIN_FULL = {1'b1, {FADE_SHIFT{1'b0}}};

    logic [FADE_SHIFT:0] gain_q;
    logic [FADE_SHIFT:0] gain_d;

    always_comb begin
        gain_d = gain_q;
        if (clear_i) begin
            gain_d = '0;
        end else if (enable_i && tick_i && (gain_q != GAIN_FULL)) begin
            gain_d = gain_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            gain_q <= '0;
        end else begin
            gain_q <= gain_d;
        end
    end

    assign gain_o = gain_q;

endmodule
`endif

// File: rtl/anc_calibration_sequencer.sv
// rtl/anc_calibration_sequencer.sv - calibration/cancellation sequencer; ANC_SEQ_FADE_EN enables the fade-in ramp
module anc_calibration_sequencer
    import anc_seq_pkg::*;
#(
    parameter int SETTLE_SAMPLES = 2400,
    parameter int RECORD_TIMEOUT = 48000,
    parameter int FADE_SHIFT     = 10
) (
    input  logic                           audio_clk,
    input  logic                           rst_in,
    input  logic                           audio_trigger,
    input  logic                           start_in,
    input  logic                           abort_in,
    input  logic [1:0]                     computing_in,
    input  logic                           impulse_recorded_in,
    input  logic                           conv_valid_in,
    input  logic signed [ANC_SAMPLE_W-1:0] conv_audio_in,
    output logic                           record_trigger_out,
    output logic                           conv_enable_out,
    output logic signed [ANC_SAMPLE_W-1:0] audio_out,
    output logic                           audio_valid_out,
    output logic [2:0]                     state_out,
    output logic                           busy_out,
    output logic                           error_out
);

    localparam logic [2:0] ST_IDLE        = ANC_IDLE;
    localparam logic [2:0] ST_SETTLE      = ANC_SETTLE;
    localparam logic [2:0] ST_OFFSET_WAIT = ANC_OFFSET_WAIT;
    localparam logic [2:0] ST_RECORD      = ANC_RECORD;
    localparam logic [2:0] ST_RUN         = ANC_RUN;
    localparam logic [2:0] ST_FAULT       = ANC_FAULT;

    localparam int CW = ANC_SEQ_CNT_W;
    localparam int GW = FADE_SHIFT + 1;
    localparam int PW = ANC_SAMPLE_W + FADE_SHIFT + 2;

    localparam logic [CW-1:0] SETTLE_LAST  = CW'(SETTLE_SAMPLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(RECORD_TIMEOUT - 1);
    localparam logic [GW-1:0] GAIN_FULL    = {1'b1, {FADE_SHIFT{1'b0}}};

    logic [2:0]                     state_q, state_d;
    logic [CW-1:0]                  cnt_q, cnt_d;
    logic                           rec_prev_q;
    logic                           rec_rise;
    logic                           enter;
    logic                           trig_q, trig_d;
    logic                           busy_q, err_q, conv_en_q;
    logic signed [ANC_SAMPLE_W-1:0] audio_q, audio_d;
    logic                           valid_q;
    logic [GW-1:0]                  gain;
    logic signed [PW-1:0]           prod;
    logic signed [PW-1:0]           prod_shift;

    // An impulse level already high when RECORD is entered never produces a rise here.
    assign rec_rise = impulse_recorded_in & ~rec_prev_q;

    always_comb begin
        state_d = state_q;
        if (abort_in) begin
            state_d = ST_IDLE;
        end else if (start_in) begin
            state_d = ST_SETTLE;
        end else begin
            case (state_q)
                ST_SETTLE: begin
                    if (audio_trigger && (cnt_q == SETTLE_LAST)) begin
                        state_d = ST_OFFSET_WAIT;
                    end
                end
                ST_OFFSET_WAIT: begin
                    if (computing_in == 2'b00) begin
                        state_d = ST_RECORD;
                    end
                end
                ST_RECORD: begin
                    if (rec_rise) begin
                        state_d = ST_RUN;
                    end else if (audio_trigger && (cnt_q == TIMEOUT_LAST)) begin
                        state_d = ST_FAULT;
                    end
                end
                ST_IDLE, ST_RUN, ST_FAULT: begin
                    state_d = state_q;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // A restart into SETTLE is an entry even though the state code does not change.
    assign enter  = abort_in | start_in | (state_d != state_q);
    assign trig_d = (state_q == ST_OFFSET_WAIT) && (state_d == ST_RECORD);

    always_comb begin
        cnt_d = cnt_q;
        if (enter) begin
            cnt_d = '0;
        end else if (audio_trigger) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

`ifdef ANC_SEQ_FADE_EN
    logic gain_clear;

    assign gain_clear = (state_q != ST_RUN) || (state_d != ST_RUN);

    fade_gain_ramp #(
        .FADE_SHIFT (FADE_SHIFT)
    ) u_fade_gain_ramp (
        .clk_i    (audio_clk),
        .rst_i    (rst_in),
        .clear_i  (gain_clear),
        .enable_i (state_q == ST_RUN),
        .tick_i   (audio_trigger),
        .gain_o   (gain)
    );
`else
    assign gain = (state_q == ST_RUN) ? GAIN_FULL : '0;
`endif

    // Gain never exceeds 2^FADE_SHIFT, so the shifted product always fits the sample width.
    assign prod       = PW'(conv_audio_in) * $signed(PW'(gain));
    assign prod_shift = prod >>> FADE_SHIFT;

    always_comb begin
        audio_d = audio_q;
        if (conv_valid_in) begin
            audio_d = (state_q == ST_RUN) ? prod_shift[ANC_SAMPLE_W-1:0] : '0;
        end
    end

    always_ff @(posedge audio_clk or posedge rst_in) begin
        if (rst_in) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            rec_prev_q <= 1'b0;
            trig_q     <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            conv_en_q  <= 1'b0;
            audio_q    <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rec_prev_q <= impulse_recorded_in;
            trig_q     <= trig_d;
            busy_q     <= is_busy_state(state_d);
            err_q      <= (state_d == ST_FAULT);
            conv_en_q  <= (state_d == ST_RUN);
            audio_q    <= audio_d;
            valid_q    <= conv_valid_in;
        end
    end

    assign record_trigger_out = trig_q;
    assign conv_enable_out    = conv_en_q;
    assign audio_out          = audio_q;
    assign audio_valid_out    = valid_q;
    assign state_out          = state_q;
    assign busy_out           = busy_q;
    assign error_out          = err_q;

endmodule
